// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and a parity helper.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit for the low nbits of data under the given mode (PAR_NONE yields the even value).
    function automatic logic parity_of(input logic [7:0] data, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j < nbits) begin
                p = p ^ data[j];
            end
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period clock-enable generator: bit_tick marks the last system cycle of each serial bit.
// Held at count 0 while restart is high so a new frame always begins on a full bit period.
module uart_baud_gen #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and serialises it LSB-first
// as start, data, optional parity and stop bits, with all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] I_DATA,
    input  logic       I_VALID,
    output logic       O_READY,
    output logic       O_DONE,
    output logic       Tx
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_state_e          state_q, state_nx;
    logic [DATA_BITS-1:0] shift_q, shift_nx;
    logic                 par_q, par_nx;
    logic [BCW-1:0]       bcnt_q, bcnt_nx;
    logic                 tx_q, tx_nx;
    logic                 ready_q;
    logic                 done_q, done_nx;
    logic                 bit_tick;
    logic                 accept;

    assign accept = I_VALID && ready_q;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (state_q == S_IDLE),
        .bit_tick (bit_tick)
    );

    // The bit counter is reused in STOP to count stop bits.
    always_comb begin
        state_nx = state_q;
        shift_nx = shift_q;
        par_nx   = par_q;
        bcnt_nx  = bcnt_q;
        done_nx  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_START;
                    shift_nx = I_DATA[DATA_BITS-1:0];
                    par_nx   = parity_of(I_DATA, DATA_BITS, PARITY);
                    bcnt_nx  = '0;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_nx = S_DATA;
                    bcnt_nx  = '0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_nx = shift_q >> 1;
                    if (bcnt_q == LAST_DATA) begin
                        bcnt_nx  = '0;
                        state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_nx = bcnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    state_nx = S_STOP;
                    bcnt_nx  = '0;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (bcnt_q == LAST_STOP) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        bcnt_nx = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so Tx changes on the same edge as the state.
    always_comb begin
        tx_nx = 1'b1;
        case (state_nx)
            S_START:  tx_nx = 1'b0;
            S_DATA:   tx_nx = shift_nx[0];
            S_PARITY: tx_nx = par_nx;
            default:  tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bcnt_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            shift_q <= shift_nx;
            par_q   <= par_nx;
            bcnt_q  <= bcnt_nx;
            tx_q    <= tx_nx;
            ready_q <= (state_nx == S_IDLE);
            done_q  <= done_nx;
        end
    end

    assign Tx      = tx_q;
    assign O_READY = ready_q;
    assign O_DONE  = done_q;

endmodule
